exp_spi_responder: RTL and testbench
====================================

Name: exp_spi_responder

Overview:
- SPI target (responder) for the expansion-board control link; the target end of the SCLK/MOSI/MISO link the FPGA drives as initiator.
- Lets an external SPI host read the board switch states and write the LED and tri-colour LED registers through a small register map.
- Sits beside the expansion GPIO block: it takes synchronised switch levels in and drives the LED register outputs that feed the GPIO write path.

Parameters:
- ID_VALUE, 8'hA5, value returned from register 0x00.
- SW_W, 8, number of switch inputs (1..8); unused upper read bits return 0.

Ports:
- clk  input  1  system clock; must be at least 8x SCLK frequency.
- reset  input  1  asynchronous, active-low reset.
- spi_sclk_in  input  1  SPI clock from host, asynchronous.
- spi_cs_n_in  input  1  chip select from host, active-low, asynchronous.
- spi_mosi_in  input  1  host-to-target data, asynchronous.
- spi_miso_out  output  1  target-to-host data.
- spi_miso_oe  output  1  MISO output enable; high only while CS is low.
- sw_in  input  SW_W  switch levels, already synchronised to clk.
- led_out  output  8  LED register (reg 0x02).
- tled_out  output  3  tri-LED register {R,G,B} (reg 0x03, bits 2:0).
- frame_err  output  1  one-clk pulse when a frame aborts early.

Behaviour:
- Reset values: spi_miso_out=0, spi_miso_oe=0, led_out=0, tled_out=0, frame_err=0, FSM=IDLE, bit counter=0.
- Synchronisation: SCLK, CS_n and MOSI each pass through 2 FF synchronisers. Edges are detected by a third register stage.
- Latency: any action taken on an SCLK edge occurs 3-4 clk after the pin edge.
- Protocol: SPI mode 0 (CPOL=0, CPHA=0), MSB first, 16-bit frame.
  - bit15 = RW (1 = read, 0 = write).
  - bits14:8 = 7-bit address.
  - bits7:0 = data.
- Register map:
  - 0x00 ID (RO).
  - 0x01 switches (RO, zero-extended sw_in).
  - 0x02 LED (RW, 8 bits).
  - 0x03 tri-LED (RW, bits 2:0; reads return 0 in bits 7:3).
  - All other addresses read 8'h00; writes to them are ignored.
  - Writes to RO registers are ignored.
- FSM:
  - IDLE: CS_n high. miso_oe=0, miso_out=0. CS_n falling edge -> CMD, bit counter cleared.
  - CMD: shift MOSI on each SCLK rise. After the 8th rise, latch RW and address.
    - Read: load the 8-bit read data into the output shift register. The switch value is sampled at this instant.
    - Then -> DATA.
  - DATA: spi_miso_out presents the shift register MSB and shifts left on each SCLK fall. MOSI is shifted in on each SCLK rise.
    - After the 16th rise, a write commits the data to the target register on the following clk. Then -> DONE.
  - DONE: further SCLK edges are ignored and miso_out is held 0. CS_n rising -> IDLE.
- miso_oe: 1 from CS_n falling detection until CS_n rising detection.
- miso_out: 0 during CMD; the read-data MSB from the clk after the 8th rise; 0 for write frames.
- Early abort: if CS_n rises in CMD, or in DATA before the 16th rise:
  - no write commit;
  - frame_err pulses for 1 clk;
  - FSM -> IDLE.
- CS_n rising and the 16th SCLK rise detected in the same clk: the commit happens; frame_err stays 0.
- Async reset mid-frame: all registers return to reset values immediately. The frame is discarded, and the next CS_n falling edge starts a fresh frame.

Optional Feature:
- Macro: EXP_SPI_AUTOINC_EN.
- Defined: after a frame completes with CS_n still low, DONE is replaced by burst mode.
  - The address increments by 1 (0x7F wraps to 0x00), followed by a further 8-bit data phase.
  - Same RW as the first frame; reads reload the shift register at each byte boundary.
  - Each byte commits or returns data exactly like a single frame.
  - An early abort inside a burst byte discards only that byte.
- Not defined: extra bits after 16 are ignored (DONE behaviour above).

Test Plan:
- Reset release, CS_n high -> miso_oe=0, miso_out=0, led_out=0x00, tled_out=0.
- Write frame 0x02 data 0x5A (bits 0_0000010_01011010) -> led_out=0x5A within 4 clk of the 16th SCLK rise; frame_err=0.
- Read 0x00 with ID_VALUE=0xA5 -> host samples 1010_0101 on SCLK rises 9-16; read 0x01 with sw_in=0x3C -> 0x3C.
- Write 0x03 data 0xFF, then read 0x03 -> tled_out=3'b111, readback 0x07; write 0x05 data 0x12 -> no register changes.
- Write 0x02 data 0x99 with CS_n raised after 12 SCLK rises -> led_out unchanged, frame_err single-clk pulse, next full frame succeeds.
- EXP_SPI_AUTOINC_EN: write burst starting 0x02 with data 0x11, 0x06 -> led_out=0x11, tled_out=3'b110. Without the macro, the same stimulus -> only led_out=0x11.

Source files
------------

// File: rtl/exp_spi_responder.sv
`timescale 1ns/1ps
// exp_spi_responder: SPI mode-0 target for the expansion-board control link.
// Gives an external host a small register map: ID, switches, LED and tri-LED.
// Ports:
//   clk, reset        system clock, asynchronous active-low reset
//   spi_sclk_in       host SPI clock (asynchronous, synchronised here)
//   spi_cs_n_in       host chip select, active-low (asynchronous)
//   spi_mosi_in       host-to-target data (asynchronous)
//   spi_miso_out      target-to-host data
//   spi_miso_oe       MISO drive enable, high for the duration of a selected frame
//   sw_in             switch levels, already synchronous to clk
//   led_out           LED register (address 0x02)
//   tled_out          tri-LED register {R,G,B} (address 0x03)
//   frame_err         one-clk pulse when a frame is aborted early
// Optional feature: define EXP_SPI_AUTOINC_EN to enable burst access with
// address auto-increment while CS_n stays low after a completed frame.
module exp_spi_responder #(
    parameter logic [7:0]  ID_VALUE = 8'hA5,
    parameter int unsigned SW_W     = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            spi_sclk_in,
    input  logic            spi_cs_n_in,
    input  logic            spi_mosi_in,
    output logic            spi_miso_out,
    output logic            spi_miso_oe,
    input  logic [SW_W-1:0] sw_in,
    output logic [7:0]      led_out,
    output logic [2:0]      tled_out,
    output logic            frame_err
);

    localparam int unsigned DATA_W = 8;
    localparam int unsigned ADDR_W = 7;
    localparam int unsigned CNT_W  = 5;
    localparam int unsigned TLED_W = 3;

    localparam logic [CNT_W-1:0]  CNT_CMD_LAST   = CNT_W'(7);
    localparam logic [CNT_W-1:0]  CNT_DATA_FIRST = CNT_W'(8);
    localparam logic [CNT_W-1:0]  CNT_DATA_LAST  = CNT_W'(15);
`ifndef EXP_SPI_AUTOINC_EN
    localparam logic [CNT_W-1:0]  CNT_END        = CNT_W'(16);
`endif

    localparam logic [ADDR_W-1:0] A_ID   = ADDR_W'(8'h00);
    localparam logic [ADDR_W-1:0] A_SW   = ADDR_W'(8'h01);
    localparam logic [ADDR_W-1:0] A_LED  = ADDR_W'(8'h02);
    localparam logic [ADDR_W-1:0] A_TLED = ADDR_W'(8'h03);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_DATA = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t state, state_nxt;

    // Pin synchronisers: [0],[1] form the 2-FF synchroniser, [2] is the edge-detect stage
    logic [2:0] sclk_sync;
    logic [2:0] cs_sync;
    logic [1:0] mosi_sync;

    logic sclk_rise, sclk_fall, cs_fall, cs_rise, mosi_bit, last_rise;

    logic [CNT_W-1:0]  bit_cnt,   bit_cnt_d;
    logic [ADDR_W-1:0] rx_sr,     rx_sr_d;
    logic [DATA_W-1:0] tx_sr,     tx_sr_d;
    logic              rw,        rw_d;
    logic [ADDR_W-1:0] addr,      addr_d;
    logic [DATA_W-1:0] led_d;
    logic [TLED_W-1:0] tled_d;
    logic              frame_err_d;
    logic [DATA_W-1:0] wr_data;
`ifdef EXP_SPI_AUTOINC_EN
    logic              burst,     burst_d;
    logic [ADDR_W-1:0] addr_inc;
`endif

    // Read-data multiplexer for the register map
    function automatic logic [DATA_W-1:0] rd_mux(
        input logic [ADDR_W-1:0] a,
        input logic [SW_W-1:0]   sw,
        input logic [DATA_W-1:0] led,
        input logic [TLED_W-1:0] tled
    );
        case (a)
            A_ID:    rd_mux = ID_VALUE;
            A_SW:    rd_mux = DATA_W'(sw);
            A_LED:   rd_mux = led;
            A_TLED:  rd_mux = DATA_W'(tled);
            default: rd_mux = '0;
        endcase
    endfunction

    // Input synchronisation; CS_n resets high so reset release never looks like a select
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sclk_sync <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
        end else begin
            sclk_sync <= {sclk_sync[1:0], spi_sclk_in};
            cs_sync   <= {cs_sync[1:0], spi_cs_n_in};
            mosi_sync <= {mosi_sync[0], spi_mosi_in};
        end
    end

    assign sclk_rise = sclk_sync[1] & ~sclk_sync[2];
    assign sclk_fall = ~sclk_sync[1] & sclk_sync[2];
    assign cs_fall   = ~cs_sync[1] & cs_sync[2];
    assign cs_rise   = cs_sync[1] & ~cs_sync[2];
    assign mosi_bit  = mosi_sync[1];
    assign last_rise = sclk_rise && (bit_cnt == CNT_DATA_LAST);
    assign wr_data   = {rx_sr, mosi_bit};
`ifdef EXP_SPI_AUTOINC_EN
    assign addr_inc  = ADDR_W'(addr + 1'b1);
`endif

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; CS_n rising always returns to IDLE
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (cs_fall) state_nxt = ST_CMD;
            ST_CMD: begin
                if (cs_rise)                                     state_nxt = ST_IDLE;
                else if (sclk_rise && (bit_cnt == CNT_CMD_LAST)) state_nxt = ST_DATA;
            end
            ST_DATA: begin
                if (cs_rise)        state_nxt = ST_IDLE;
`ifdef EXP_SPI_AUTOINC_EN
                else if (last_rise) state_nxt = ST_DATA;
`else
                else if (last_rise) state_nxt = ST_DONE;
`endif
            end
            ST_DONE: if (cs_rise) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Datapath / output next values
    always_comb begin
        bit_cnt_d   = bit_cnt;
        rx_sr_d     = rx_sr;
        tx_sr_d     = tx_sr;
        rw_d        = rw;
        addr_d      = addr;
        led_d       = led_out;
        tled_d      = tled_out;
        frame_err_d = 1'b0;
`ifdef EXP_SPI_AUTOINC_EN
        burst_d     = burst;
`endif
        case (state)
            ST_IDLE: begin
                if (cs_fall) begin
                    bit_cnt_d = '0;
`ifdef EXP_SPI_AUTOINC_EN
                    burst_d   = 1'b0;
`endif
                end
            end
            ST_CMD: begin
                if (cs_rise) begin
                    frame_err_d = 1'b1;
                end else if (sclk_rise) begin
                    rx_sr_d   = {rx_sr[ADDR_W-2:0], mosi_bit};
                    bit_cnt_d = CNT_W'(bit_cnt + 1'b1);
                    if (bit_cnt == CNT_CMD_LAST) begin
                        // Command byte complete: rx_sr[6] is RW, remaining bits plus MOSI form the address
                        rw_d   = rx_sr[ADDR_W-1];
                        addr_d = {rx_sr[ADDR_W-2:0], mosi_bit};
                        if (rx_sr[ADDR_W-1]) begin
                            tx_sr_d = rd_mux({rx_sr[ADDR_W-2:0], mosi_bit}, sw_in, led_out, tled_out);
                        end
                    end
                end
            end
            ST_DATA: begin
                // A 16th rise coinciding with CS_n rising still commits cleanly
                if (last_rise) begin
                    if (!rw) begin
                        case (addr)
                            A_LED:   led_d  = wr_data;
                            A_TLED:  tled_d = wr_data[TLED_W-1:0];
                            default: ;
                        endcase
                    end
`ifdef EXP_SPI_AUTOINC_EN
                    bit_cnt_d = CNT_DATA_FIRST;
                    addr_d    = addr_inc;
                    burst_d   = 1'b1;
                    if (rw) begin
                        tx_sr_d = rd_mux(addr_inc, sw_in, led_out, tled_out);
                    end
`else
                    bit_cnt_d = CNT_END;
`endif
                end else if (cs_rise) begin
`ifdef EXP_SPI_AUTOINC_EN
                    // Deselect on a burst byte boundary ends the burst cleanly
                    frame_err_d = !(burst && (bit_cnt == CNT_DATA_FIRST));
`else
                    frame_err_d = 1'b1;
`endif
                end else if (sclk_rise) begin
                    rx_sr_d   = {rx_sr[ADDR_W-2:0], mosi_bit};
                    bit_cnt_d = CNT_W'(bit_cnt + 1'b1);
                end else if (sclk_fall && (bit_cnt > CNT_DATA_FIRST)) begin
                    // The fall right after a load is skipped so the MSB is held for the next rise
                    tx_sr_d = {tx_sr[DATA_W-2:0], 1'b0};
                end
            end
            default: ;
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bit_cnt      <= '0;
            rx_sr        <= '0;
            tx_sr        <= '0;
            rw           <= 1'b0;
            addr         <= '0;
            led_out      <= '0;
            tled_out     <= '0;
            frame_err    <= 1'b0;
            spi_miso_out <= 1'b0;
            spi_miso_oe  <= 1'b0;
`ifdef EXP_SPI_AUTOINC_EN
            burst        <= 1'b0;
`endif
        end else begin
            bit_cnt      <= bit_cnt_d;
            rx_sr        <= rx_sr_d;
            tx_sr        <= tx_sr_d;
            rw           <= rw_d;
            addr         <= addr_d;
            led_out      <= led_d;
            tled_out     <= tled_d;
            frame_err    <= frame_err_d;
            spi_miso_out <= (state_nxt == ST_DATA) && rw_d && tx_sr_d[DATA_W-1];
            spi_miso_oe  <= (state_nxt != ST_IDLE);
`ifdef EXP_SPI_AUTOINC_EN
            burst        <= burst_d;
`endif
        end
    end

endmodule

// File: tb/tb_exp_spi_responder.sv
`timescale 1ns/1ps
// tb_exp_spi_responder: directed host-side frames with a read-data scoreboard.
module tb_exp_spi_responder;

    logic       clk;
    logic       rst_n;
    logic       spi_sclk_in;
    logic       spi_cs_n_in;
    logic       spi_mosi_in;
    logic       spi_miso_out;
    logic       spi_miso_oe;
    logic [7:0] sw_in;
    logic [7:0] led_out;
    logic [2:0] tled_out;
    logic       frame_err;

    int total = 0;
    int bad   = 0;

    // frame_err pulse monitor
    int   err_pulses = 0;
    int   err_long   = 0;
    logic err_prev   = 1'b0;

    logic [7:0] exp_q[$];

    exp_spi_responder #(.ID_VALUE(8'hA5), .SW_W(8)) dut (
        .clk          (clk),
        .reset        (rst_n),
        .spi_sclk_in  (spi_sclk_in),
        .spi_cs_n_in  (spi_cs_n_in),
        .spi_mosi_in  (spi_mosi_in),
        .spi_miso_out (spi_miso_out),
        .spi_miso_oe  (spi_miso_oe),
        .sw_in        (sw_in),
        .led_out      (led_out),
        .tled_out     (tled_out),
        .frame_err    (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_err && err_prev)  err_long++;
        if (frame_err && !err_prev) err_pulses++;
        err_prev = frame_err;
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s: observed=%02h expected=%02h", tag, obs, exp_v);
        end
    endtask

    // Host-side frame: tx is MSB-aligned, SCLK period 160 ns (16 clk)
    task automatic spi_xfer(input logic [31:0] tx, input int n_rises,
                            output logic [31:0] rx, output logic [7:0] led_snap,
                            output logic oe_snap);
        rx          = '0;
        led_snap    = led_out;
        spi_cs_n_in = 1'b0;
        #100;
        oe_snap = spi_miso_oe;
        for (int i = 0; i < n_rises; i++) begin
            spi_mosi_in = tx[31-i];
            #80;
            spi_sclk_in = 1'b1;
            rx = {rx[30:0], spi_miso_out};
            #40;
            if (i == 15) led_snap = led_out;
            #40;
            spi_sclk_in = 1'b0;
        end
        #80;
        spi_cs_n_in = 1'b1;
        spi_mosi_in = 1'b0;
        #100;
    endtask

    task automatic do_write(input string tag, input logic [6:0] a, input logic [7:0] d,
                            output logic [7:0] led_snap);
        logic [31:0] rx;
        logic        oe;
        spi_xfer({1'b0, a, d, 16'h0000}, 16, rx, led_snap, oe);
        chk({tag, "_oe"}, 8'(oe), 8'h01);
        chk({tag, "_miso0"}, rx[7:0], 8'h00);
    endtask

    // Read frame of nbytes data bytes; expected bytes must already be queued
    task automatic do_read(input string tag, input logic [6:0] a, input int nbytes);
        logic [31:0] rx;
        logic [7:0]  snap;
        logic        oe;
        logic [7:0]  e;
        spi_xfer({1'b1, a, 24'h000000}, 8 + 8 * nbytes, rx, snap, oe);
        chk({tag, "_oe"}, 8'(oe), 8'h01);
        chk({tag, "_cmdmiso"}, rx[8*nbytes +: 8], 8'h00);
        for (int k = 0; k < nbytes; k++) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $error("FAIL %s_sb: observed=empty expected=queued byte", tag);
            end else begin
                e = exp_q.pop_front();
                chk({tag, "_data"}, rx[8*(nbytes-1-k) +: 8], e);
            end
        end
    endtask

    initial begin
        logic [7:0]  snap;
        logic [31:0] rx;
        logic        oe;
        int          base;

        rst_n       = 1'b0;
        spi_sclk_in = 1'b0;
        spi_cs_n_in = 1'b1;
        spi_mosi_in = 1'b0;
        sw_in       = 8'h00;
        #50;
        rst_n = 1'b1;
        #40;

        // Reset state
        chk("rst_oe",   8'(spi_miso_oe),  8'h00);
        chk("rst_miso", 8'(spi_miso_out), 8'h00);
        chk("rst_led",  led_out,          8'h00);
        chk("rst_tled", 8'(tled_out),     8'h00);
        chk("rst_ferr", 8'(frame_err),    8'h00);

        // LED write, visible within 4 clk of the 16th rise
        base = err_pulses;
        do_write("wr_led", 7'h02, 8'h5A, snap);
        chk("wr_led_4clk", snap, 8'h5A);
        chk("wr_led_ferr", 8'(err_pulses - base), 8'h00);

        // ID and switch reads
        exp_q.push_back(8'hA5);
        do_read("rd_id", 7'h00, 1);
        sw_in = 8'h3C;
        exp_q.push_back(8'h3C);
        do_read("rd_sw", 7'h01, 1);
        exp_q.push_back(8'h5A);
        do_read("rd_led", 7'h02, 1);

        // Tri-LED write keeps only bits 2:0
        do_write("wr_tled", 7'h03, 8'hFF, snap);
        chk("wr_tled_val", 8'(tled_out), 8'h07);
        exp_q.push_back(8'h07);
        do_read("rd_tled", 7'h03, 1);

        // Unmapped address: write ignored, read zero
        do_write("wr_unmap", 7'h05, 8'h12, snap);
        chk("wr_unmap_led",  led_out,      8'h5A);
        chk("wr_unmap_tled", 8'(tled_out), 8'h07);
        exp_q.push_back(8'h00);
        do_read("rd_unmap", 7'h05, 1);

        // Write to a read-only register is ignored
        do_write("wr_ro", 7'h00, 8'h33, snap);
        exp_q.push_back(8'hA5);
        do_read("rd_id2", 7'h00, 1);

        // Abort in the data phase after 12 rises
        base = err_pulses;
        spi_xfer({1'b0, 7'h02, 8'h99, 16'h0000}, 12, rx, snap, oe);
        chk("abort_led",   led_out, 8'h5A);
        chk("abort_ferr",  8'(err_pulses - base), 8'h01);
        chk("abort_width", 8'(err_long), 8'h00);

        // Abort in the command phase after 4 rises
        base = err_pulses;
        spi_xfer({1'b0, 7'h02, 8'h77, 16'h0000}, 4, rx, snap, oe);
        chk("abort_cmd_led",  led_out, 8'h5A);
        chk("abort_cmd_ferr", 8'(err_pulses - base), 8'h01);

        // Next full frame after an abort succeeds
        base = err_pulses;
        do_write("wr_after", 7'h02, 8'hC3, snap);
        chk("wr_after_led",  led_out, 8'hC3);
        chk("wr_after_ferr", 8'(err_pulses - base), 8'h00);

        // 24-bit write frame starting at 0x02
        base = err_pulses;
        spi_xfer({1'b0, 7'h02, 8'h11, 8'h06, 8'h00}, 24, rx, snap, oe);
        chk("burst_led", led_out, 8'h11);
`ifdef EXP_SPI_AUTOINC_EN
        chk("burst_tled", 8'(tled_out), 8'h06);
`else
        chk("burst_tled", 8'(tled_out), 8'h07);
`endif
        chk("burst_ferr", 8'(err_pulses - base), 8'h00);

        // 24-bit read frame starting at 0x02
        exp_q.push_back(8'h11);
`ifdef EXP_SPI_AUTOINC_EN
        exp_q.push_back(8'h06);
`else
        exp_q.push_back(8'h00);
`endif
        do_read("rd_burst", 7'h02, 2);

        // Asynchronous reset in the middle of a frame
        spi_cs_n_in = 1'b0;
        #100;
        for (int i = 0; i < 5; i++) begin
            spi_mosi_in = 1'b1;
            #80;
            spi_sclk_in = 1'b1;
            #80;
            spi_sclk_in = 1'b0;
        end
        #40;
        rst_n = 1'b0;
        #3;
        chk("mid_rst_oe",   8'(spi_miso_oe), 8'h00);
        chk("mid_rst_led",  led_out,         8'h00);
        chk("mid_rst_tled", 8'(tled_out),    8'h00);
        spi_cs_n_in = 1'b1;
        spi_mosi_in = 1'b0;
        #47;
        rst_n = 1'b1;
        #100;
        chk("post_rst_oe", 8'(spi_miso_oe), 8'h00);
        do_write("wr_post_rst", 7'h02, 8'h3C, snap);
        chk("wr_post_rst_led", led_out, 8'h3C);
        exp_q.push_back(8'hA5);
        do_read("rd_post_rst", 7'h00, 1);

        chk("sb_drained", 8'(exp_q.size()), 8'h00);
        chk("ferr_width", 8'(err_long), 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global time bound
    initial begin
        #2000000;
        $display("FAIL timeout: observed=no finish expected=finish within bound");
        $fatal(1, "timeout");
    end

endmodule
